fxp_mul_fsm: RTL and testbench

- Sequential signed two's-complement fixed-point multiplier, radix-2 shift-add, one multiplier bit per cycle.
- Counterpart of the team's iterative fixed-point divider in the postprocess chain: same handshake (i_vld / ready / o_vld), same IDLE/BUSY/OUTPUT flow.
- Typical use is rescaling FFT magnitudes by gains, as opposed to dividing by them.
- Adds rounding (floor) and saturation to the output format, with an overflow flag.

---
 rtl/fxp_pkg.sv | 25 ++
 rtl/fxp_mul_resize.sv | 53 +++++
 rtl/fxp_mul_fsm.sv | 143 ++++++++++++++
 tb/tb_fxp_mul_fsm.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// fxp_pkg
// Shared definitions for the iterative fixed-point postprocess blocks (the
// multiplier and its divider counterpart).
//   fxp_state_t   : IDLE / BUSY / OUTPUT flow shared by both engines
//   fxp_max_int(n): largest value of an n-bit signed word
//   fxp_min_int(n): smallest value of an n-bit signed word
package fxp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      OUTPUT = 2'b10
   } fxp_state_t;

   // Upper saturation bound of an n-bit two's-complement word, 0111..1
   function automatic longint fxp_max_int(input int n);
      return (longint'(1) <<< (n - 1)) - longint'(1);
   endfunction

   // Lower saturation bound of an n-bit two's-complement word, 1000..0
   function automatic longint fxp_min_int(input int n);
      return -(longint'(1) <<< (n - 1));
   endfunction

endpackage

// File: rtl/fxp_mul_resize.sv
// fxp_mul_resize
// Combinational format converter: signed (WII.WIF) -> signed (WOI.WOF).
// Surplus fraction bits are dropped with an arithmetic shift, which floors
// toward -inf; missing fraction bits are zero-padded. Values outside the
// output range clamp to the nearest bound and raise overflow.
//   prodIn    : signed input word, WII integer bits (incl. sign), WIF fraction bits
//   resultOut : signed output word, WOI integer bits (incl. sign), WOF fraction bits
//   overflow  : 1 when resultOut was clamped
module fxp_mul_resize
   import fxp_pkg::*;
#(
   parameter int WII = 17,
   parameter int WIF = 16,
   parameter int WOI = 8,
   parameter int WOF = 8
) (
   input  logic signed [WII+WIF-1:0] prodIn,
   output logic        [WOI+WOF-1:0] resultOut,
   output logic                      overflow
);

   localparam int WP  = WII + WIF;
   localparam int WO  = WOI + WOF;
   localparam int SHR = (WIF > WOF) ? (WIF - WOF) : 0;
   localparam int SHL = (WOF > WIF) ? (WOF - WIF) : 0;
   // Working width holds the left-aligned input and the output bounds with
   // one bit of headroom so the range compares are never truncated.
   localparam int WX  = (((WP + SHL) > WO) ? (WP + SHL) : WO) + 1;

   localparam logic signed [WX-1:0] MAX_VAL = WX'(fxp_max_int(WO));
   localparam logic signed [WX-1:0] MIN_VAL = WX'(fxp_min_int(WO));

   logic signed [WX-1:0] widened;
   logic signed [WX-1:0] scaled;

   // Align the binary point to WOF fraction bits, then clamp to the output
   // range. The arithmetic right shift is what gives floor rounding for
   // negative values.
   always_comb begin
      widened   = WX'(prodIn);
      scaled    = (widened <<< SHL) >>> SHR;
      resultOut = scaled[WO-1:0];
      overflow  = 1'b0;
      if (scaled > MAX_VAL) begin
         resultOut = {1'b0, {(WO-1){1'b1}}};
         overflow  = 1'b1;
      end else if (scaled < MIN_VAL) begin
         resultOut = {1'b1, {(WO-1){1'b0}}};
         overflow  = 1'b1;
      end
   end

endmodule

// File: rtl/fxp_mul_fsm.sv
// fxp_mul_fsm
// Sequential signed fixed-point multiplier, radix-2 shift-add, one multiplier
// bit per cycle. Operands are reduced to magnitudes plus a sign on accept,
// the unsigned product is accumulated over WB cycles, and the signed product
// is floored/saturated into the output format as the result loads.
//   clk          : clock, rising edge
//   rst          : synchronous reset, active-high
//   i_vld        : operands valid, taken when i_vld & ready
//   multiplicand : signed a, WIIA.WIFA
//   multiplier   : signed b, WIIB.WIFB
//   out          : registered signed result, WOI.WOF
//   ovf          : result was saturated, valid with o_vld
//   o_vld        : one-cycle result-valid pulse
//   ready        : operands can be accepted (not BUSY)
module fxp_mul_fsm
   import fxp_pkg::*;
#(
   parameter int WIIA = 8,
   parameter int WIFA = 8,
   parameter int WIIB = 8,
   parameter int WIFB = 8,
   parameter int WOI  = 8,
   parameter int WOF  = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_vld,
   input  logic signed [WIIA+WIFA-1:0] multiplicand,
   input  logic signed [WIIB+WIFB-1:0] multiplier,
   output logic        [WOI+WOF-1:0]   out,
   output logic                        ovf,
   output logic                        o_vld,
   output logic                        ready
);

   localparam int WA = WIIA + WIFA;
   localparam int WB = WIIB + WIFB;
   localparam int WM = WA + WB;
   localparam int WO = WOI + WOF;
   localparam int CW = $clog2(WB + 1);

   fxp_state_t state;
   fxp_state_t stateNext;

   logic [WA-1:0]        aMagIn;
   logic [WB-1:0]        bMagIn;
   logic [WM-1:0]        aShift;
   logic [WB-1:0]        bShift;
   logic [WM-1:0]        acc;
   logic [WM-1:0]        accNext;
   logic                 prodSign;
   logic [CW-1:0]        cnt;
   logic                 accept;
   logic                 lastBit;
   logic signed [WM:0]   prodSigned;
   logic [WO-1:0]        resized;
   logic                 resizedOvf;

   assign ready   = (state != BUSY);
   assign accept  = i_vld & ready;
   assign lastBit = (state == BUSY) && (cnt == CW'(WB - 1));

   // Operand magnitudes. The most negative input negates to itself, which is
   // still the correct magnitude once read as unsigned.
   always_comb begin
      aMagIn = multiplicand[WA-1] ? -multiplicand : multiplicand;
      bMagIn = multiplier[WB-1]   ? -multiplier   : multiplier;
   end

   // One shift-add step: the multiplicand is pre-shifted in aShift and the
   // multiplier bit under test is always bShift[0]. The signed product is
   // formed from accNext so the final addition and the output load share
   // the same edge.
   always_comb begin
      accNext    = acc + (bShift[0] ? aShift : '0);
      prodSigned = prodSign ? -$signed({1'b0, accNext}) : $signed({1'b0, accNext});
   end

   fxp_mul_resize #(
      .WII(WIIA + WIIB + 1),
      .WIF(WIFA + WIFB),
      .WOI(WOI),
      .WOF(WOF)
   ) uResize (
      .prodIn   (prodSigned),
      .resultOut(resized),
      .overflow (resizedOvf)
   );

   // Next-state logic: an OUTPUT cycle can take new operands directly so a
   // held i_vld gives back-to-back operations with no IDLE gap.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (i_vld) stateNext = BUSY;
         BUSY:    if (cnt == CW'(WB - 1)) stateNext = OUTPUT;
         OUTPUT:  stateNext = i_vld ? BUSY : IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // Datapath and result registers. Reset clears the partial product and the
   // visible result, so an aborted operation leaves out=0 and never pulses
   // o_vld. The counter is sized to hold WB, the value it reaches on the
   // final step.
   always_ff @(posedge clk) begin
      if (rst) begin
         aShift   <= '0;
         bShift   <= '0;
         acc      <= '0;
         prodSign <= 1'b0;
         cnt      <= '0;
         out      <= '0;
         ovf      <= 1'b0;
         o_vld    <= 1'b0;
      end else begin
         o_vld <= lastBit;
         if (accept) begin
            aShift   <= {{WB{1'b0}}, aMagIn};
            bShift   <= bMagIn;
            prodSign <= multiplicand[WA-1] ^ multiplier[WB-1];
            acc      <= '0;
            cnt      <= '0;
         end else if (state == BUSY) begin
            acc    <= accNext;
            aShift <= aShift << 1;
            bShift <= bShift >> 1;
            cnt    <= cnt + 1'b1;
         end
         if (lastBit) begin
            out <= resized;
            ovf <= resizedOvf;
         end
      end
   end

endmodule

// File: tb/tb_fxp_mul_fsm.sv
// tb_fxp_mul_fsm
// Directed and randomized checks of fxp_mul_fsm at the default Q8.8 formats.
// Expected results come from an integer reference model: full signed product,
// floor rescale to WOF fraction bits, clamp to the WO-bit signed range.
module tb_fxp_mul_fsm;

   localparam int WIIA = 8;
   localparam int WIFA = 8;
   localparam int WIIB = 8;
   localparam int WIFB = 8;
   localparam int WOI  = 8;
   localparam int WOF  = 8;
   localparam int WA   = WIIA + WIFA;
   localparam int WB   = WIIB + WIFB;
   localparam int WO   = WOI + WOF;
   localparam int FIN  = WIFA + WIFB;
   localparam int WAIT_LIMIT = 40;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          iVld = 1'b0;
   logic [WA-1:0] multiplicand = '0;
   logic [WB-1:0] multiplier = '0;
   logic [WO-1:0] outRes;
   logic          ovf;
   logic          oVld;
   logic          ready;

   int checks = 0;
   int errors = 0;

   fxp_mul_fsm #(
      .WIIA(WIIA), .WIFA(WIFA), .WIIB(WIIB), .WIFB(WIFB), .WOI(WOI), .WOF(WOF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_vld       (iVld),
      .multiplicand(multiplicand),
      .multiplier  (multiplier),
      .out         (outRes),
      .ovf         (ovf),
      .o_vld       (oVld),
      .ready       (ready)
   );

   always #5 clk = ~clk;

   // Safety net in case a bounded wait is somehow bypassed.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model written from the arithmetic definition, not the RTL.
   function automatic void refModel(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                    output logic [WO-1:0] res, output logic sat);
      longint p, hi, lo;
      p = longint'($signed(a)) * longint'($signed(b));
      if (FIN > WOF) p = p >>> (FIN - WOF);
      else           p = p <<< (WOF - FIN);
      hi  = (longint'(1) <<< (WO - 1)) - 1;
      lo  = -hi - 1;
      sat = 1'b0;
      if (p > hi) begin p = hi; sat = 1'b1; end
      else if (p < lo) begin p = lo; sat = 1'b1; end
      res = p[WO-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Presents operands for exactly one accept edge, returns just after it.
   task automatic applyStimulus(input logic [WA-1:0] a, input logic [WB-1:0] b);
      multiplicand = a;
      multiplier   = b;
      iVld         = 1'b1;
      tick();
      iVld         = 1'b0;
   endtask

   // Waits (bounded) for o_vld, counting edges from the accept edge, and
   // checks latency, ready low while busy, and the result.
   task automatic waitResult(input int edgesSoFar, input logic [WO-1:0] expOut,
                             input logic expOvf, input string tag);
      int lat;
      logic readyLow;
      lat      = edgesSoFar;
      readyLow = 1'b1;
      while (oVld !== 1'b1 && lat < WAIT_LIMIT) begin
         if (ready !== 1'b0) readyLow = 1'b0;
         tick();
         lat++;
      end
      checkOutput({tag, ".latency"}, 32'(lat), 32'(WB));
      checkOutput({tag, ".readyLow"}, 32'(readyLow), 32'(1));
      checkOutput({tag, ".out"}, 32'(outRes), 32'(expOut));
      checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expOvf));
   endtask

   task automatic runOp(input logic [WA-1:0] a, input logic [WB-1:0] b,
                        input logic [WO-1:0] expOut, input logic expOvf,
                        input string tag);
      applyStimulus(a, b);
      waitResult(0, expOut, expOvf, tag);
      tick();
      checkOutput({tag, ".pulse"}, 32'(oVld), 32'(0));
      checkOutput({tag, ".hold"}, 32'(outRes), 32'(expOut));
   endtask

   initial begin
      logic [WA-1:0] ra;
      logic [WB-1:0] rb;
      logic [WO-1:0] eo;
      logic          ev;
      logic          seen;
      logic [WA-1:0] opsA [3];
      logic [WB-1:0] opsB [3];

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset.out", 32'(outRes), 32'(0));
      checkOutput("reset.ovf", 32'(ovf), 32'(0));
      checkOutput("reset.oVld", 32'(oVld), 32'(0));
      checkOutput("reset.ready", 32'(ready), 32'(1));

      // Directed cases
      runOp(16'h0180, 16'h0200, 16'h0300, 1'b0, "pos");
      runOp(16'hFE80, 16'h0200, 16'hFD00, 1'b0, "neg");
      runOp(16'h8000, 16'hFF00, 16'h7FFF, 1'b1, "minTimesM1");
      runOp(16'h6400, 16'h6400, 16'h7FFF, 1'b1, "satHi");
      runOp(16'h6400, 16'h9C00, 16'h8000, 1'b1, "satLo");
      runOp(16'h0001, 16'h0001, 16'h0000, 1'b0, "floorPos");
      runOp(16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, "floorNeg");
      runOp(16'h0000, 16'h8000, 16'h0000, 1'b0, "zeroNeg");

      // i_vld pulse with different operands during BUSY is ignored
      refModel(16'h0240, 16'hFD80, eo, ev);
      applyStimulus(16'h0240, 16'hFD80);
      tick();
      tick();
      tick();
      multiplicand = 16'h7FFF;
      multiplier   = 16'h7FFF;
      iVld         = 1'b1;
      tick();
      iVld         = 1'b0;
      waitResult(4, eo, ev, "busyPulse");
      tick();

      // Back-to-back with i_vld held high
      for (int k = 0; k < 3; k++) begin
         opsA[k] = WA'($urandom());
         opsB[k] = WB'($urandom());
      end
      multiplicand = opsA[0];
      multiplier   = opsB[0];
      iVld         = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         refModel(opsA[k], opsB[k], eo, ev);
         if (k < 2) begin
            multiplicand = opsA[k+1];
            multiplier   = opsB[k+1];
         end else begin
            iVld = 1'b0;
         end
         waitResult(0, eo, ev, $sformatf("b2b%0d", k));
         tick();
         if (k < 2) checkOutput($sformatf("b2b%0d.noIdle", k), 32'(ready), 32'(0));
      end

      // Randomized operands against the model
      for (int n = 0; n < 20; n++) begin
         ra = WA'($urandom());
         rb = WB'($urandom());
         if (n == 0) ra = 16'h8000;
         if (n == 1) rb = 16'h8000;
         refModel(ra, rb, eo, ev);
         runOp(ra, rb, eo, ev, $sformatf("rand%0d", n));
      end

      // Reset in the middle of BUSY
      applyStimulus(16'h0300, 16'h0200);
      for (int k = 0; k < 5; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midRst.ready", 32'(ready), 32'(1));
      checkOutput("midRst.out", 32'(outRes), 32'(0));
      checkOutput("midRst.oVld", 32'(oVld), 32'(0));
      seen = 1'b0;
      for (int k = 0; k < WB + 5; k++) begin
         if (oVld !== 1'b0) seen = 1'b1;
         tick();
      end
      checkOutput("midRst.noPulse", 32'(seen), 32'(0));
      runOp(16'hFF00, 16'hFF00, 16'h0100, 1'b0, "afterRst");

      // Reset and i_vld together: reset wins, engine stays idle
      multiplicand = 16'h0100;
      multiplier   = 16'h0100;
      iVld         = 1'b1;
      rst          = 1'b1;
      tick();
      rst          = 1'b0;
      iVld         = 1'b0;
      checkOutput("rstWins.ready", 32'(ready), 32'(1));
      seen = 1'b0;
      for (int k = 0; k < WB + 3; k++) begin
         if (oVld !== 1'b0) seen = 1'b1;
         tick();
      end
      checkOutput("rstWins.noPulse", 32'(seen), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
